// File: rtl/alu_op_sequencer.sv
// Purpose : sequences one ALU command through register read, execute and write-back.
// Latency : accept at edge k -> o_done high between edges k+2 and k+3, register write lands at edge k+3.
// Backpr. : o_cmd_ready is high only in IDLE; one command per 4 cycles, command fields ignored while busy.
//
// Ports:
//   i_clk, i_rst_n (async, active-low)
//   i_cmd_valid/o_cmd_ready, i_cmd_src1/src2/dest, i_cmd_op, i_cmd_nowb : command handshake and fields
//   o_rf_addr1/addr2 + i_rf_data_a/b : register-file reads (combinational read data)
//   o_rf_dest/o_rf_wdata/o_rf_write  : register-file write-back
//   o_alu_srca/srcb/op + i_alu_result/zero : external combinational ALU
//   o_done, o_result, o_zero, o_busy, o_cmd_count : status
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [AW-1:0]    i_cmd_src1,
  input  logic [AW-1:0]    i_cmd_src2,
  input  logic [AW-1:0]    i_cmd_dest,
  input  logic             i_cmd_op,
  input  logic             i_cmd_nowb,
  output logic [AW-1:0]    o_rf_addr1,
  output logic [AW-1:0]    o_rf_addr2,
  output logic [AW-1:0]    o_rf_dest,
  output logic [WIDTH-1:0] o_rf_wdata,
  output logic             o_rf_write,
  input  logic [WIDTH-1:0] i_rf_data_a,
  input  logic [WIDTH-1:0] i_rf_data_b,
  output logic [WIDTH-1:0] o_alu_srca,
  output logic [WIDTH-1:0] o_alu_srcb,
  output logic             o_alu_op,
  input  logic [WIDTH-1:0] i_alu_result,
  input  logic             i_alu_zero,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_busy,
  output logic [7:0]       o_cmd_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t           r_state;
  logic [AW-1:0]    r_src1;
  logic [AW-1:0]    r_src2;
  logic [AW-1:0]    r_dest;
  logic             r_op;
  logic             r_nowb;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_rf_write;
  logic             r_done;
  logic             r_cmd_ready;
  logic [7:0]       r_count;

  // Write enable and done are registered on the EXEC->WB transition so they
  // are high exactly for the WB cycle and never combinationally from inputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_src1      <= '0;
      r_src2      <= '0;
      r_dest      <= '0;
      r_op        <= 1'b0;
      r_nowb      <= 1'b0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_rf_write  <= 1'b0;
      r_done      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_count     <= '0;
    end else begin
      r_rf_write <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            r_src1      <= i_cmd_src1;
            r_src2      <= i_cmd_src2;
            r_dest      <= i_cmd_dest;
            r_op        <= i_cmd_op;
            r_nowb      <= i_cmd_nowb;
            r_cmd_ready <= 1'b0;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          r_opa   <= i_rf_data_a;
          r_opb   <= i_rf_data_b;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          // NOWB commands still refresh result and zero flag.
          r_result   <= i_alu_result;
          r_zero     <= i_alu_zero;
          r_rf_write <= ~r_nowb;
          r_done     <= 1'b1;
          r_state    <= S_WB;
        end
        S_WB: begin
          r_count     <= r_count + 8'd1;
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_cmd_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  // All outputs come straight from registers, so they hold their last value
  // outside the states that use them.
  assign o_cmd_ready = r_cmd_ready;
  assign o_busy      = ~r_cmd_ready;
  assign o_rf_addr1  = r_src1;
  assign o_rf_addr2  = r_src2;
  assign o_rf_dest   = r_dest;
  assign o_rf_wdata  = r_result;
  assign o_rf_write  = r_rf_write;
  assign o_alu_srca  = r_opa;
  assign o_alu_srcb  = r_opb;
  assign o_alu_op    = r_op;
  assign o_done      = r_done;
  assign o_result    = r_result;
  assign o_zero      = r_zero;
  assign o_cmd_count = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  localparam int WIDTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_src1 = '0;
  logic [AW-1:0]    cmd_src2 = '0;
  logic [AW-1:0]    cmd_dest = '0;
  logic             cmd_op = 1'b0;
  logic             cmd_nowb = 1'b0;
  logic [AW-1:0]    rf_addr1, rf_addr2, rf_dest;
  logic [WIDTH-1:0] rf_wdata;
  logic             rf_write;
  logic [WIDTH-1:0] rf_data_a, rf_data_b;
  logic [WIDTH-1:0] alu_srca, alu_srcb;
  logic             alu_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             busy;
  logic [7:0]       cmd_count;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(WIDTH), .AW(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_src1(cmd_src1), .i_cmd_src2(cmd_src2), .i_cmd_dest(cmd_dest),
    .i_cmd_op(cmd_op), .i_cmd_nowb(cmd_nowb),
    .o_rf_addr1(rf_addr1), .o_rf_addr2(rf_addr2), .o_rf_dest(rf_dest),
    .o_rf_wdata(rf_wdata), .o_rf_write(rf_write),
    .i_rf_data_a(rf_data_a), .i_rf_data_b(rf_data_b),
    .o_alu_srca(alu_srca), .o_alu_srcb(alu_srcb), .o_alu_op(alu_op),
    .i_alu_result(alu_result), .i_alu_zero(alu_zero),
    .o_done(done), .o_result(result), .o_zero(zero),
    .o_busy(busy), .o_cmd_count(cmd_count)
  );

  // Environment: register file with a bench-side preload port, and the ALU.
  logic [WIDTH-1:0] rf [16];
  logic             pl_en = 1'b0;
  logic [AW-1:0]    pl_addr = '0;
  logic [WIDTH-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) rf[pl_addr] <= pl_data;
    else if (rf_write) rf[rf_dest] <= rf_wdata;
  end
  assign rf_data_a  = rf[rf_addr1];
  assign rf_data_b  = rf[rf_addr2];
  assign alu_result = alu_op ? (alu_srca - alu_srcb) : (alu_srca + alu_srcb);
  assign alu_zero   = (alu_result == '0);

  int wr_cnt = 0;
  int done_cnt = 0;
  always @(posedge clk) begin
    if (rf_write) wr_cnt <= wr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Reference model: architectural register contents and status.
  logic [WIDTH-1:0] ref_rf [16];
  logic [WIDTH-1:0] ref_result = '0;
  logic             ref_zero = 1'b0;
  logic [7:0]       ref_count = '0;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_cmd(input logic [AW-1:0] s1, s2, d, input logic op, nowb);
    logic [WIDTH-1:0] r;
    r = op ? (ref_rf[s1] - ref_rf[s2]) : (ref_rf[s1] + ref_rf[s2]);
    ref_result = r;
    ref_zero   = (r == '0);
    if (!nowb) ref_rf[d] = r;
    ref_count  = ref_count + 8'd1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [WIDTH-1:0] v);
    pl_en = 1'b1; pl_addr = a; pl_data = v;
    ref_rf[a] = v;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic scramble_fields();
    cmd_src1 = AW'($urandom_range(0, 15));
    cmd_src2 = AW'($urandom_range(0, 15));
    cmd_dest = AW'($urandom_range(0, 15));
    cmd_op   = 1'($urandom_range(0, 1));
    cmd_nowb = 1'($urandom_range(0, 1));
  endtask

  // Called at a negedge with the sequencer idle (or about to be); returns at
  // the negedge after the WB cycle.
  task automatic do_cmd(input logic [AW-1:0] s1, s2, d, input logic op, nowb,
                        input bit scramble, output int waited);
    int lat;
    int wr0, dn0;
    cmd_src1 = s1; cmd_src2 = s2; cmd_dest = d; cmd_op = op; cmd_nowb = nowb;
    cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", cmd_ready, 1);
    wr0 = wr_cnt; dn0 = done_cnt;
    @(posedge clk);
    model_cmd(s1, s2, d, op, nowb);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (scramble) scramble_fields();
    lat = 1;
    while (!done && lat < 8) begin
      @(negedge clk);
      lat++;
      if (scramble) scramble_fields();
    end
    check("done_latency", lat, 3);
    check("wb_write_en", rf_write, !nowb);
    check("wb_dest", rf_dest, d);
    check("wb_wdata", rf_wdata, ref_result);
    check("wb_busy", busy, 1);
    @(negedge clk);
    check("result", result, ref_result);
    check("zero", zero, ref_zero);
    check("cmd_count", cmd_count, ref_count);
    check("rf_dest_value", rf[d], ref_rf[d]);
    check("write_pulses", wr_cnt - wr0, nowb ? 0 : 1);
    check("done_pulses", done_cnt - dn0, 1);
    check("ready_after_wb", cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int wr0, dn0;
    logic [WIDTH-1:0] r6;

    // Reset state, with the register file loaded while reset is held.
    rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) preload(AW'(i), WIDTH'($urandom));
    check("rst_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_write", rf_write, 0);
    check("rst_result", result, 0);
    check("rst_zero", zero, 0);
    check("rst_count", cmd_count, 0);
    check("rst_addr1", rf_addr1, 0);
    check("rst_dest", rf_dest, 0);
    check("rst_srca", alu_srca, 0);

    // 5+3 into R4, accepted on the first edge after reset release.
    preload(1, 16'd5);
    preload(2, 16'd3);
    rst_n = 1'b1;
    do_cmd(1, 2, 4, 1'b0, 1'b0, 1'b0, w);
    check("first_accept_wait", w, 0);
    check("add_r4", rf[4], 16'd8);
    check("add_result", result, 16'd8);
    check("add_count", cmd_count, 1);

    // 5-5 with no write-back: zero flag set, R4 untouched.
    preload(2, 16'd5);
    do_cmd(1, 2, 4, 1'b1, 1'b1, 1'b0, w);
    check("nowb_result", result, 0);
    check("nowb_zero", zero, 1);
    check("nowb_r4", rf[4], 16'd8);

    // Back-to-back dependent commands with valid held high.
    preload(2, 16'd3);
    cmd_src1 = 1; cmd_src2 = 2; cmd_dest = 4; cmd_op = 1'b0; cmd_nowb = 1'b0;
    cmd_valid = 1'b1;
    model_cmd(1, 2, 4, 1'b0, 1'b0);
    model_cmd(4, 1, 5, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) begin
      check("b2b_ready", cmd_ready, (i % 4) == 0);
      check("b2b_done", done, (i % 4) == 3);
      if (i == 1) begin
        cmd_src1 = 4; cmd_src2 = 1; cmd_dest = 5;
      end
      if (i == 5) cmd_valid = 1'b0;
      @(negedge clk);
    end
    check("b2b_r4", rf[4], 16'd8);
    check("b2b_r5", rf[5], 16'd13);
    check("b2b_result", result, 16'd13);
    check("b2b_count", cmd_count, ref_count);

    // Randomized commands; fields are scrambled while the command is in flight.
    for (int i = 0; i < 40; i++) begin
      if ((i % 8) == 0) preload(AW'($urandom_range(0, 15)), WIDTH'($urandom));
      do_cmd(AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
             AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0), 1'b1, w);
    end

    // Ensure a non-zero result is showing, then reset during EXEC.
    preload(7, 16'd100);
    do_cmd(7, 7, 8, 1'b0, 1'b0, 1'b0, w);
    r6 = rf[6];
    cmd_src1 = 7; cmd_src2 = 8; cmd_dest = 6; cmd_op = 1'b0; cmd_nowb = 1'b0;
    cmd_valid = 1'b1;
    wr0 = wr_cnt; dn0 = done_cnt;
    @(negedge clk);       // READ
    cmd_valid = 1'b0;
    @(negedge clk);       // EXEC
    rst_n = 1'b0;
    #1;
    ref_result = '0; ref_zero = 1'b0; ref_count = '0;
    check("abort_ready", cmd_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_result", result, ref_result);
    check("abort_zero", zero, ref_zero);
    check("abort_count", cmd_count, ref_count);
    check("abort_write", rf_write, 0);
    check("abort_done", done, 0);
    repeat (3) @(negedge clk);
    check("abort_no_write", wr_cnt - wr0, 0);
    check("abort_no_done", done_cnt - dn0, 0);
    check("abort_r6", rf[6], r6);
    rst_n = 1'b1;

    // Counter wrap: 256 NOWB commands from reset.
    for (int i = 0; i < 256; i++)
      do_cmd(AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
             AW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1, 1'b0, w);
    check("wrap_256", cmd_count, 0);
    do_cmd(1, 2, 3, 1'b0, 1'b1, 1'b0, w);
    check("wrap_257", cmd_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 Parameter WIDTH, 16, datapath width of register file, ALU and result SHALL be WIDTH bits.
REQ-002 Parameter AW, 4, register address width (16 registers) SHALL size all address ports.
REQ-003 CLOCK  in  1  single clock; all state SHALL update on rising edge.
REQ-004 RESET_N  in  1  reset SHALL be asynchronous, active-low.
REQ-005 CMD_VALID  in  1  command present.
REQ-006 CMD_READY  out  1  sequencer accepts command this cycle.
REQ-007 CMD_SRC1 / CMD_SRC2 / CMD_DEST  in  AW each  source A, source B, destination register.
REQ-008 CMD_OP  in  1  ALU operation code, passed unmodified to ALU_OP.
REQ-009 CMD_NOWB  in  1  1 = compute and flag only, no register write-back.
REQ-010 RF_ADDR1 / RF_ADDR2 / RF_DEST  out  AW each  register-file read and write addresses.
REQ-011 RF_WDATA  out  WIDTH  write data; RF_WRITE  out  1  write enable.
REQ-012 RF_DATA_A / RF_DATA_B  in  WIDTH  combinational read data from register file.
REQ-013 ALU_SRCA / ALU_SRCB  out  WIDTH  ALU operands; ALU_OP  out  1  ALU operation.
REQ-014 ALU_RESULT  in  WIDTH, ALU_ZERO  in  1  combinational ALU outputs.
REQ-015 DONE  out  1  one-cycle completion pulse; RESULT  out  WIDTH  last result; ZERO  out  1  last zero flag.
REQ-016 BUSY  out  1  command in flight; CMD_COUNT  out  8  completed-command counter.

Function
REQ-017 FSM states SHALL be IDLE, READ, EXEC, WB; encoding is implementer's choice.
REQ-018 CMD_READY SHALL equal 1 exactly when state is IDLE; BUSY SHALL equal its inverse.
REQ-019 Handshake: CMD_VALID & CMD_READY at a rising edge SHALL latch SRC1, SRC2, DEST, OP, NOWB and move IDLE->READ; command fields SHALL be ignored at all other times.
REQ-020 READ: RF_ADDR1/RF_ADDR2 SHALL drive latched SRC1/SRC2; RF_DATA_A/B SHALL be captured into operand registers at the edge ending READ; READ->EXEC unconditionally.
REQ-021 EXEC: ALU_SRCA/ALU_SRCB SHALL drive captured operands, ALU_OP latched OP; ALU_RESULT and ALU_ZERO SHALL be captured into RESULT and ZERO at the edge ending EXEC; EXEC->WB.
REQ-022 WB: RF_DEST=latched DEST, RF_WDATA=RESULT, RF_WRITE=~latched NOWB, for exactly one cycle; DONE=1 this cycle; WB->IDLE.
REQ-023 Latency: handshake at edge k SHALL give DONE high during cycle between edges k+2 and k+3; register write SHALL land at edge k+3.
REQ-024 Throughput: one command per 4 cycles; CMD_READY SHALL reassert the cycle after WB.
REQ-025 Back-to-back dependency (next command reads previous DEST) SHALL see the newly written value with no extra stall.
REQ-026 RF_WRITE SHALL be 0 in every state except WB; DONE SHALL be 0 except in WB.
REQ-027 RESULT and ZERO SHALL hold their values until the next EXEC capture, including across NOWB commands (which still update them).
REQ-028 CMD_COUNT SHALL increment by 1 at the edge ending each WB, wrapping 255->0.
REQ-029 Outside READ/EXEC/WB, address/operand outputs SHALL hold last values (no X); no combinational path from CMD_* to RF_*/ALU_* outputs.
REQ-030 CMD_VALID deasserting while BUSY SHALL have no effect on the in-flight command.

Reset
REQ-031 RESET_N low SHALL immediately force state IDLE, RF_WRITE=0, DONE=0, CMD_READY=1, BUSY=0, RESULT=0, ZERO=0, CMD_COUNT=0, all latched command and operand registers 0.
REQ-032 Reset asserted mid-command (any of READ/EXEC/WB) SHALL abort it: no write-back, no DONE, counter unchanged.
REQ-033 First command SHALL be accepted at the first rising edge after RESET_N deasserts with CMD_VALID high.

Verification
REQ-034 R1=5, R2=3, cmd SRC1=1 SRC2=2 DEST=4 OP=0 (add) -> DONE 3 cycles after accept, R4=8, RESULT=8, ZERO=0, CMD_COUNT=1.
REQ-035 R1=5, R2=5, OP=1 (sub), NOWB=1, DEST=4 -> RESULT=0, ZERO=1, RF_WRITE never asserted, R4 unchanged.
REQ-036 CMD_VALID held high with two commands (R4=R1+R2, then R5=R4+R1) -> second accepted cycle after first DONE, R5=13, CMD_READY low 3 cycles per command.
REQ-037 RESET_N pulsed low during EXEC -> RF_WRITE stays 0, no DONE, RESULT=0, CMD_COUNT=0, CMD_READY=1 immediately.
REQ-038 256 NOWB commands from reset -> CMD_COUNT wraps to 0; 257th -> 1.
REQ-039 CMD_SRC/DEST changed while BUSY -> outputs and write-back use fields latched at accept.
